// File: rtl/vector_element_sequencer.sv
// vector_element_sequencer
//   Splits a vector instruction of length vl into groups of NUM_LANES
//   consecutive elements and presents one group per cycle to the lanes.
//   Supports a restart index (vstart), downstream stall, exception capture
//   of the faulting group's element index, and flush.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   issue_valid/ready   instruction handshake; issue_vl, issue_vstart payload
//   stall, exc, flush   per-group control from the lanes / pipeline
//   offset, lane_en     element index of lane 0 and per-lane valid
//   group_valid         group presented this cycle
//   last_group          presented group is the final one
//   done                one-cycle completion pulse
//   busy                instruction in progress
//   exc_vstart          element index captured on exception
module vector_element_sequencer #(
    parameter int NUM_LANES = 2,
    parameter int VLMAX     = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [31:0]          issue_vl,
    input  logic [31:0]          issue_vstart,
    input  logic                 stall,
    input  logic                 exc,
    input  logic                 flush,
    output logic [31:0]          offset,
    output logic [NUM_LANES-1:0] lane_en,
    output logic                 group_valid,
    output logic                 last_group,
    output logic                 done,
    output logic                 busy,
    output logic [31:0]          exc_vstart
);

    localparam logic [31:0] VLMAX_W = 32'(VLMAX);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] offset_q, offset_d;
    logic [31:0] vl_eff_q, vl_eff_d;
    logic [31:0] exc_vstart_q, exc_vstart_d;

    logic [31:0] vl_clamped;
    logic [32:0] grp_end;
    logic        is_last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            offset_q     <= '0;
            vl_eff_q     <= '0;
            exc_vstart_q <= '0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            vl_eff_q     <= vl_eff_d;
            exc_vstart_q <= exc_vstart_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        vl_eff_d     = vl_eff_q;
        exc_vstart_d = exc_vstart_q;

        vl_clamped = (issue_vl > VLMAX_W) ? VLMAX_W : issue_vl;
        // 33-bit sum so offset near 2^32 cannot wrap past vl_eff
        grp_end    = {1'b0, offset_q} + 33'(NUM_LANES);
        is_last    = grp_end >= {1'b0, vl_eff_q};

        unique case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    vl_eff_d = vl_clamped;
                    // vl_eff == 0 is covered: any vstart is then >= vl_eff
                    if (issue_vstart >= vl_clamped) begin
                        state_d  = FIN;
                        offset_d = '0;
                    end else begin
                        state_d  = RUN;
                        offset_d = issue_vstart;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d  = IDLE;
                    offset_d = '0;
                end else if (exc) begin
                    exc_vstart_d = offset_q;
                    state_d      = IDLE;
                    offset_d     = '0;
                end else if (!stall) begin
                    if (is_last) begin
                        state_d = FIN;
                    end else begin
                        offset_d = grp_end[31:0];
                    end
                end
            end
            FIN: begin
                state_d  = IDLE;
                offset_d = '0;
            end
            default: begin
                state_d  = IDLE;
                offset_d = '0;
            end
        endcase
    end

    always_comb begin
        issue_ready = (state_q == IDLE);
        group_valid = (state_q == RUN);
        last_group  = group_valid & is_last;
        done        = (state_q == FIN) & ~flush;
        busy        = (state_q != IDLE);
        offset      = offset_q;
        exc_vstart  = exc_vstart_q;
        lane_en     = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_en[i] = group_valid & (({1'b0, offset_q} + 33'(i)) < {1'b0, vl_eff_q});
        end
    end

endmodule

// File: tb/tb_vector_element_sequencer.sv
module tb_vector_element_sequencer;

    localparam int NL = 2;
    localparam int VM = 32;

    logic          CLK;
    logic          RST;
    logic          issue_valid;
    logic          issue_ready;
    logic [31:0]   issue_vl;
    logic [31:0]   issue_vstart;
    logic          stall;
    logic          exc;
    logic          flush;
    logic [31:0]   offset;
    logic [NL-1:0] lane_en;
    logic          group_valid;
    logic          last_group;
    logic          done;
    logic          busy;
    logic [31:0]   exc_vstart;

    vector_element_sequencer #(.NUM_LANES(NL), .VLMAX(VM)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_vl(issue_vl), .issue_vstart(issue_vstart),
        .stall(stall), .exc(exc), .flush(flush),
        .offset(offset), .lane_en(lane_en),
        .group_valid(group_valid), .last_group(last_group),
        .done(done), .busy(busy), .exc_vstart(exc_vstart)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // abort kinds: 0 none, 1 exc, 2 flush, 3 reset
    typedef struct {
        logic [31:0] vl;
        logic [31:0] vstart;
        int          stall_off;
        int          stall_n;
        int          abort_kind;
        int          abort_off;
        int          exp_groups;
    } vec_t;

    typedef struct {
        logic [31:0]   off;
        logic [NL-1:0] en;
        logic          last;
    } grp_t;

    vec_t tbl[12];
    grp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_offset"}, 64'(offset), 0);
        chk({name, "_lane_en"}, 64'(lane_en), 0);
        chk({name, "_group_valid"}, 64'(group_valid), 0);
        chk({name, "_last_group"}, 64'(last_group), 0);
        chk({name, "_done"}, 64'(done), 0);
        chk({name, "_busy"}, 64'(busy), 0);
        chk({name, "_exc_vstart"}, 64'(exc_vstart), 0);
    endtask

    task automatic run_instr(input int idx, input vec_t v);
        string       nm;
        longint      vle;
        int          ngroups;
        int          seen;
        int          stalls_left;
        bit          finished;
        bit          aborted;
        logic [31:0] exc_before;
        grp_t        g;

        nm  = $sformatf("v%0d", idx);
        vle = (v.vl > 32'(VM)) ? longint'(VM) : longint'(v.vl);
        sb.delete();

        @(negedge CLK);
        chk({nm, "_ready"}, 64'(issue_ready), 1);
        issue_valid  = 1'b1;
        issue_vl     = v.vl;
        issue_vstart = v.vstart;
        exc_before   = exc_vstart;

        ngroups = 0;
        for (longint off = longint'(v.vstart); off < vle; off += NL) begin
            g.off  = 32'(off);
            g.last = (off + NL) >= vle;
            for (int i = 0; i < NL; i++) g.en[i] = (off + i) < vle;
            sb.push_back(g);
            ngroups++;
        end

        seen        = 0;
        stalls_left = v.stall_n;
        finished    = 1'b0;
        aborted     = 1'b0;
        for (int cyc = 1; cyc <= 100 && !finished; cyc++) begin
            @(negedge CLK);
            issue_valid = 1'b0;
            stall = 1'b0;
            exc   = 1'b0;
            flush = 1'b0;
            if (cyc == 1) begin
                chk({nm, "_busy"}, 64'(busy), 1);
                chk({nm, "_first_gv"}, 64'(group_valid), 64'(ngroups > 0));
            end
            if (group_valid) begin
                if (sb.size() == 0) begin
                    chk({nm, "_extra_group"}, 64'(offset), 64'hFFFF_FFFF_FFFF_FFFF);
                    finished = 1'b1;
                end else begin
                    chk({nm, "_offset"}, 64'(offset), 64'(sb[0].off));
                    chk({nm, "_lane_en"}, 64'(lane_en), 64'(sb[0].en));
                    chk({nm, "_last"}, 64'(last_group), 64'(sb[0].last));
                    if (v.abort_kind != 0 && offset == 32'(v.abort_off)) begin
                        aborted  = 1'b1;
                        finished = 1'b1;
                        if (v.abort_kind == 1) exc = 1'b1;
                        else if (v.abort_kind == 2) flush = 1'b1;
                        else begin
                            RST = 1'b1;
                            #1;
                            check_reset_outputs({nm, "_in_rst"});
                        end
                    end else if (stalls_left > 0 && offset == 32'(v.stall_off)) begin
                        stall = 1'b1;
                        stalls_left--;
                    end
                    if (!stall && !aborted) begin
                        void'(sb.pop_front());
                        seen++;
                    end
                end
            end
            if (!aborted && done) begin
                chk({nm, "_done_cycle"}, 64'(cyc), 64'(ngroups + v.stall_n + 1));
                finished = 1'b1;
            end
        end
        if (!finished) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_groups"}, 64'(seen), 64'(v.exp_groups));

        @(negedge CLK);
        exc   = 1'b0;
        flush = 1'b0;
        if (v.abort_kind == 3) begin
            RST = 1'b0;
            @(negedge CLK);
        end
        if (!aborted) chk({nm, "_sb_empty"}, 64'(sb.size()), 0);
        chk({nm, "_post_ready"}, 64'(issue_ready), 1);
        chk({nm, "_post_busy"}, 64'(busy), 0);
        chk({nm, "_post_done"}, 64'(done), 0);
        if (v.abort_kind == 1) chk({nm, "_exc_vstart"}, 64'(exc_vstart), 64'(v.abort_off));
        if (v.abort_kind == 2) chk({nm, "_exc_keep"}, 64'(exc_vstart), 64'(exc_before));
        if (v.abort_kind == 3) chk({nm, "_exc_rst"}, 64'(exc_vstart), 0);
        if (aborted) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge CLK);
                chk({nm, "_no_done"}, 64'(done), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          vl            vstart soff sn ak aoff groups
        tbl[0]  = '{32'd5,        32'd0,  0, 0, 0, 0, 3};
        tbl[1]  = '{32'd4,        32'd1,  0, 0, 0, 0, 2};
        tbl[2]  = '{32'd6,        32'd0,  2, 3, 0, 0, 3};
        tbl[3]  = '{32'd8,        32'd0,  0, 0, 1, 4, 2};
        tbl[4]  = '{32'd8,        32'd4,  0, 0, 0, 0, 2};
        tbl[5]  = '{32'd0,        32'd0,  0, 0, 0, 0, 0};
        tbl[6]  = '{32'd3,        32'd3,  0, 0, 0, 0, 0};
        tbl[7]  = '{32'd40,       32'd0,  0, 0, 0, 0, 16};
        tbl[8]  = '{32'd6,        32'd0,  0, 0, 2, 2, 1};
        tbl[9]  = '{32'd8,        32'd0,  0, 0, 3, 2, 1};
        tbl[10] = '{32'd7,        32'd5,  0, 0, 0, 0, 1};
        tbl[11] = '{32'hFFFF_FFFF, 32'd31, 0, 0, 0, 0, 1};

        RST          = 1'b1;
        issue_valid  = 1'b0;
        issue_vl     = '0;
        issue_vstart = '0;
        stall        = 1'b0;
        exc          = 1'b0;
        flush        = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_release_ready", 64'(issue_ready), 1);

        for (int t = 0; t < 12; t++) run_instr(t, tbl[t]);

        // issue_valid held high through an instruction: only one handshake
        @(negedge CLK);
        issue_valid  = 1'b1;
        issue_vl     = 32'd4;
        issue_vstart = 32'd0;
        @(negedge CLK);
        chk("hold_ready_low", 64'(issue_ready), 0);
        chk("hold_off0", 64'(offset), 0);
        @(negedge CLK);
        chk("hold_off2", 64'(offset), 2);
        chk("hold_last", 64'(last_group), 1);
        issue_valid = 1'b0;
        @(negedge CLK);
        chk("hold_done", 64'(done), 1);
        @(negedge CLK);
        chk("hold_idle", 64'(issue_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
